// File: rtl/up2_mem_ctrl.sv
// UART byte-command sequencer for the up2 board memory: parses 'W' addr data / 'R' addr,
// issues single-cycle memory strobes and returns one response byte per command.
module up2_mem_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]  OP_WR   = 8'h57;
  localparam logic [7:0]  OP_RD   = 8'h52;
  localparam logic [7:0]  RSP_OK  = 8'h4B;
  localparam logic [7:0]  RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR, S_RD, S_RDW, S_RESP
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               is_wr, is_wr_d;
  logic               bad, bad_d;
  logic               tx_valid_d;
  logic [7:0]         tx_data_d;
  logic               mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         mem_wdata_d;
  logic               busy_d, err_d;
  logic               err_set_c;
  logic               addr_bad_c;
  logic               timeout_c;

  assign addr_bad_c = (rx_data >> ADDR_W) != 8'd0;
  assign timeout_c  = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state and next-output logic; every output below is registered.
  always_comb begin
    state_d     = state;
    cnt_d       = '0;
    is_wr_d     = is_wr;
    bad_d       = bad;
    tx_valid_d  = tx_valid;
    tx_data_d   = tx_data;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    err_set_c   = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          bad_d = 1'b0;
          if (rx_data == OP_WR) begin
            is_wr_d = 1'b1;
            state_d = S_ADDR;
          end else if (rx_data == OP_RD) begin
            is_wr_d = 1'b0;
            state_d = S_ADDR;
          end else begin
            err_set_c  = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ERR;
            state_d    = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          if (addr_bad_c) begin
            err_set_c = 1'b1;
            // A bad write still consumes its data byte before answering.
            if (is_wr) begin
              bad_d   = 1'b1;
              state_d = S_DATA;
            end else begin
              tx_valid_d = 1'b1;
              tx_data_d  = RSP_ERR;
              state_d    = S_RESP;
            end
          end else begin
            mem_addr_d = rx_data[ADDR_W-1:0];
            if (is_wr) begin
              state_d = S_DATA;
            end else begin
              mem_en_d = 1'b1;
              state_d  = S_RD;
            end
          end
        end else if (timeout_c) begin
          err_set_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          if (bad) begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ERR;
            state_d    = S_RESP;
          end else begin
            mem_wdata_d = rx_data;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            state_d     = S_WR;
          end
        end else if (timeout_c) begin
          err_set_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_WR: begin
        err_set_c  = rx_valid;
        tx_valid_d = 1'b1;
        tx_data_d  = RSP_OK;
        state_d    = S_RESP;
      end

      S_RD: begin
        err_set_c = rx_valid;
        state_d   = S_RDW;
      end

      S_RDW: begin
        err_set_c  = rx_valid;
        tx_valid_d = 1'b1;
        tx_data_d  = mem_rdata;
        state_d    = S_RESP;
      end

      S_RESP: begin
        err_set_c = rx_valid;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    err_d  = err_clr ? 1'b0 : (err | err_set_c);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      bad       <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      is_wr     <= is_wr_d;
      bad       <= bad_d;
      tx_valid  <= tx_valid_d;
      tx_data   <= tx_data_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule
